sd_sector_initiator: RTL and testbench
======================================

Name: sd_sector_initiator

Overview:
- Core-side initiator of the HPS virtual-disk sector protocol: sd_lba, sd_rd/sd_wr, sd_ack, sd_buff_*.
- Accepts one-sector read or write requests from a disk controller (e.g. the D88 FDD emulation).
- Drives the request toward the HPS responder and holds the 512-byte sector in a local dual-port buffer.
- Reports completion, byte-count errors and timeouts back to the controller.

Parameters:
- LBA_W, 32, width of the sector address.
- TIMEOUT, 50_000_000, clk_sys cycles to wait for sd_ack rise before aborting.
- SECT_BYTES, 512, bytes per sector; buffer address width is log2(SECT_BYTES).

Ports:
- clk_sys  in  1  system clock; all logic is on this edge.
- reset  in  1  synchronous, active-high reset.
- req_rd  in  1  single-cycle pulse: read sector req_lba into the buffer.
- req_wr  in  1  single-cycle pulse: write the buffer to sector req_lba.
- req_lba  in  LBA_W  sector address, sampled on the accepting cycle.
- busy  out  1  high from the accept cycle until the done/err cycle, inclusive.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout or short read.
- buf_addr  in  9  controller-side buffer address.
- buf_wdata  in  8  controller-side write data.
- buf_we  in  1  controller-side write enable; ignored while busy.
- buf_rdata  out  8  controller-side read data, 1-cycle latency, readable at any time.
- sd_lba  out  LBA_W  latched request address toward the HPS.
- sd_rd  out  1  read request toward the HPS.
- sd_wr  out  1  write request toward the HPS.
- sd_ack  in  1  HPS acknowledge, high for the duration of the transfer.
- sd_buff_addr  in  9  HPS buffer address.
- sd_buff_dout  in  8  HPS data for reads.
- sd_buff_wr  in  1  HPS byte strobe for reads.
- sd_buff_din  out  8  buffer data for writes, registered, valid 1 cycle after sd_buff_addr.

Behaviour:
- Reset state: busy, done, err, sd_rd and sd_wr are 0; sd_lba is 0; FSM is IDLE. Buffer contents are not cleared.
- Reset mid-operation immediately drops sd_rd/sd_wr. No done or err pulse is produced. An sd_ack still high after reset is ignored until it falls.
- State IDLE: req_rd or req_wr latches req_lba into sd_lba and the direction, then goes to REQ.
  - busy rises on the next cycle.
  - If req_rd and req_wr arrive together, the read wins.
- Requests arriving while busy are dropped silently.
- State REQ: sd_rd (or sd_wr) is high and the timeout counter runs.
  - sd_ack rising (registered edge detect) clears the request bit and goes to XFER.
  - If the counter reaches TIMEOUT-1, drop the request, pulse err, return to IDLE.
- State XFER: sd_ack is high.
  - Read: each sd_buff_wr writes sd_buff_dout to buffer[sd_buff_addr] and increments a 10-bit byte counter. The counter saturates at 512.
  - Write: sd_buff_din = buffer[sd_buff_addr] registered on each clock.
  - sd_ack falling goes to FIN.
- State FIN (one cycle):
  - Read with count == 512: pulse done.
  - Read with count != 512: pulse err.
  - Write: always pulse done.
  - Then return to IDLE; busy falls in the same cycle as the pulse ends.
- sd_buff_wr outside XFER or during a write transfer has no effect on the buffer.
- Controller buf_we is honoured only in IDLE. When ports collide, the SD port has priority, which is consistent with the IDLE-only rule.
- Latency from request pulse to sd_rd high: 1 cycle. From sd_ack fall to done: 2 cycles.

Decomposition:
- Package sd_xfer_pkg holds:
  - the FSM state enum {IDLE, REQ, XFER, FIN};
  - SECT_BYTES and BUF_AW constants;
  - the default TIMEOUT.
- Sub-module sector_dpram: true dual-port 512x8 RAM with a registered read on each port, single clock clk_sys. Port A is the controller side; port B is the SD side.

Test Plan:
- Read: req_rd with lba 0x00000123 → sd_rd=1 and sd_lba=0x123 next cycle. Responder raises sd_ack after 10 cycles, then writes bytes addr^0x5A for addr 0..511, then drops sd_ack → exactly one done pulse 2 cycles later, err=0. Reading buf_addr 0x1FF returns 0xA5.
- Write: preload the buffer via buf_we with data = addr[7:0], then req_wr lba 7 → sd_wr high until sd_ack rises. The responder sampling sd_buff_din one cycle after each address sees 0x00..0xFF twice. Ends with a done pulse.
- Timeout: TIMEOUT=100, req_rd, sd_ack never asserted → sd_rd drops and err pulses at cycle 100 after accept, busy=0 afterwards, no done.
- Short read: responder sends only 300 sd_buff_wr strobes then drops sd_ack → err pulse, no done. The first 300 bytes are updated and the rest are unchanged.
- Collisions: req_rd and req_wr in the same cycle → sd_rd only. A second req_wr while busy → ignored, exactly one done. buf_we while busy → buffer unchanged.
- Reset mid-XFER: assert reset with sd_ack high → sd_rd/sd_wr/busy are 0 next cycle, no done/err. A new req_rd after sd_ack falls completes normally.

Source files
------------

// File: rtl/sd_xfer_pkg.sv
// Shared types and constants for the HPS virtual-disk sector initiator.
package sd_xfer_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

  localparam int SECT_BYTES      = 512;
  localparam int BUF_AW          = $clog2(SECT_BYTES);
  localparam int DEFAULT_TIMEOUT = 50_000_000;

endpackage

// File: rtl/sector_dpram.sv
// True dual-port sector RAM, registered read on both ports, one clock.
// Port A is the controller side, port B the SD side; B's write lands last.
module sector_dpram
  import sd_xfer_pkg::*;
#(
  parameter int DEPTH = SECT_BYTES,
  parameter int AW    = BUF_AW,
  parameter int DW    = 8
) (
  input  logic          clk_sys,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_sys) begin
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

endmodule

// File: rtl/sd_sector_initiator.sv
// Core-side initiator for one-sector HPS reads/writes through a local buffer.
// Reports done on success, err on sd_ack timeout or a short read.
module sd_sector_initiator
  import sd_xfer_pkg::*;
#(
  parameter int LBA_W      = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int SECT_BYTES = sd_xfer_pkg::SECT_BYTES
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          req_rd,
  input  logic                          req_wr,
  input  logic [LBA_W-1:0]              req_lba,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic [$clog2(SECT_BYTES)-1:0] buf_addr,
  input  logic [7:0]                    buf_wdata,
  input  logic                          buf_we,
  output logic [7:0]                    buf_rdata,
  output logic [LBA_W-1:0]              sd_lba,
  output logic                          sd_rd,
  output logic                          sd_wr,
  input  logic                          sd_ack,
  input  logic [$clog2(SECT_BYTES)-1:0] sd_buff_addr,
  input  logic [7:0]                    sd_buff_dout,
  input  logic                          sd_buff_wr,
  output logic [7:0]                    sd_buff_din
);

  localparam int AW = $clog2(SECT_BYTES);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t           state_reg, state_next;
  logic             dir_wr_reg, dir_wr_next;
  logic [LBA_W-1:0] lba_reg, lba_next;
  logic [TW-1:0]    to_cnt_reg, to_cnt_next;
  logic [CW-1:0]    byte_cnt_reg, byte_cnt_next;
  logic             ack_q1_reg, ack_q2_reg;

  logic ack_rise, ack_fall, timeout_hit, full_sector;
  logic a_we, b_we;

  assign ack_rise    = ack_q1_reg & ~ack_q2_reg;
  assign ack_fall    = ~ack_q1_reg & ack_q2_reg;
  assign timeout_hit = (state_reg == REQ) && !ack_rise && (to_cnt_reg == TW'(TIMEOUT - 1));
  assign full_sector = (byte_cnt_reg == CW'(SECT_BYTES));

  // Edge-detect history resets high so an sd_ack left over from an aborted
  // transfer cannot look like a fresh rise.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= IDLE;
      dir_wr_reg   <= 1'b0;
      lba_reg      <= '0;
      to_cnt_reg   <= '0;
      byte_cnt_reg <= '0;
      ack_q1_reg   <= 1'b1;
      ack_q2_reg   <= 1'b1;
    end else begin
      state_reg    <= state_next;
      dir_wr_reg   <= dir_wr_next;
      lba_reg      <= lba_next;
      to_cnt_reg   <= to_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      ack_q1_reg   <= sd_ack;
      ack_q2_reg   <= ack_q1_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dir_wr_next   = dir_wr_reg;
    lba_next      = lba_reg;
    to_cnt_next   = to_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_rd || req_wr) begin
          state_next    = REQ;
          dir_wr_next   = !req_rd;
          lba_next      = req_lba;
          to_cnt_next   = '0;
          byte_cnt_next = '0;
        end
      end
      REQ: begin
        if (ack_rise)         state_next = XFER;
        else if (timeout_hit) state_next = IDLE;
        else                  to_cnt_next = to_cnt_reg + 1'b1;
      end
      XFER: begin
        if (sd_buff_wr && !dir_wr_reg && !full_sector)
          byte_cnt_next = byte_cnt_reg + 1'b1;
        if (ack_fall) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE);
    sd_lba = lba_reg;
    sd_rd  = (state_reg == REQ) && !dir_wr_reg && !timeout_hit;
    sd_wr  = (state_reg == REQ) &&  dir_wr_reg && !timeout_hit;
    done   = (state_reg == FIN) && (dir_wr_reg || full_sector);
    err    = ((state_reg == FIN) && !dir_wr_reg && !full_sector) || timeout_hit;
    a_we   = buf_we && (state_reg == IDLE);
    b_we   = sd_buff_wr && (state_reg == XFER) && !dir_wr_reg;
  end

  sector_dpram #(
    .DEPTH (SECT_BYTES),
    .AW    (AW),
    .DW    (8)
  ) u_buf (
    .clk_sys (clk_sys),
    .a_we    (a_we),
    .a_addr  (buf_addr),
    .a_wdata (buf_wdata),
    .a_rdata (buf_rdata),
    .b_we    (b_we),
    .b_addr  (sd_buff_addr),
    .b_wdata (sd_buff_dout),
    .b_rdata (sd_buff_din)
  );

endmodule

// File: tb/tb_sd_sector_initiator.sv
// Directed bench for sd_sector_initiator with a completion/byte scoreboard
// and a small HPS responder model.
module tb_sd_sector_initiator;

  logic        clk_sys      = 1'b0;
  logic        reset        = 1'b1;
  logic        req_rd       = 1'b0;
  logic        req_wr       = 1'b0;
  logic [31:0] req_lba      = '0;
  logic        busy, done, err;
  logic [8:0]  buf_addr     = '0;
  logic [7:0]  buf_wdata    = '0;
  logic        buf_we       = 1'b0;
  logic [7:0]  buf_rdata;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack       = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0;
  logic        sd_buff_wr   = 1'b0;
  logic [7:0]  sd_buff_din;

  int n_total = 0;
  int n_pass  = 0;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  logic [1:0] exp_ev_q[$];
  logic [7:0] exp_byte_q[$];

  always #5 clk_sys = ~clk_sys;

  sd_sector_initiator #(
    .LBA_W      (32),
    .TIMEOUT    (100),
    .SECT_BYTES (512)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_lba      (req_lba),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .buf_addr     (buf_addr),
    .buf_wdata    (buf_wdata),
    .buf_we       (buf_we),
    .buf_rdata    (buf_rdata),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Every done/err pulse must match the next expected completion.
  always @(negedge clk_sys) begin
    if (!reset && (done || err)) begin
      if (exp_ev_q.size() == 0)
        check("unexpected_pulse", 32'({done, err}), 32'd0);
      else
        check("completion", 32'({done, err}), 32'(exp_ev_q.pop_front()));
    end
  end

  task automatic rd_buf(input string tag, input int addr, input logic [7:0] exp);
    buf_addr = 9'(addr);
    tick();
    check(tag, 32'(buf_rdata), 32'(exp));
  endtask

  task automatic do_read(input logic [31:0] lba, input int nbytes, input logic [7:0] key);
    logic [1:0] ev;
    ev      = (nbytes == 512) ? EV_DONE : EV_ERR;
    req_lba = lba;
    req_rd  = 1'b1;
    tick();
    req_rd  = 1'b0;
    check("rd_sd_rd", 32'(sd_rd), 32'd1);
    check("rd_sd_wr", 32'(sd_wr), 32'd0);
    check("rd_sd_lba", sd_lba, lba);
    check("rd_busy", 32'(busy), 32'd1);
    repeat (10) tick();
    sd_ack = 1'b1;
    repeat (4) tick();
    check("rd_req_cleared", 32'(sd_rd), 32'd0);
    for (int a = 0; a < nbytes; a++) begin
      sd_buff_addr = 9'(a);
      sd_buff_dout = 8'(a) ^ key;
      sd_buff_wr   = 1'b1;
      tick();
    end
    sd_buff_wr = 1'b0;
    tick();
    exp_ev_q.push_back(ev);
    sd_ack = 1'b0;
    tick();
    check("rd_no_early_pulse", 32'({done, err}), 32'd0);
    tick();
    check("rd_pulse", 32'({done, err}), 32'(ev));
    tick();
    check("rd_pulse_single", 32'({done, err}), 32'd0);
    check("rd_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] lba, input bit collide);
    req_lba = lba;
    req_wr  = 1'b1;
    tick();
    req_wr  = 1'b0;
    check("wr_sd_wr", 32'(sd_wr), 32'd1);
    check("wr_sd_rd", 32'(sd_rd), 32'd0);
    check("wr_sd_lba", sd_lba, lba);
    if (collide) begin
      req_wr    = 1'b1;
      req_lba   = 32'h55;
      buf_addr  = 9'd10;
      buf_wdata = 8'hEE;
      buf_we    = 1'b1;
      tick();
      req_wr = 1'b0;
      buf_we = 1'b0;
      check("wr_busy_req_dropped", sd_lba, lba);
    end
    repeat (5) tick();
    check("wr_sd_wr_held", 32'(sd_wr), 32'd1);
    sd_ack = 1'b1;
    repeat (2) tick();
    check("wr_req_cleared", 32'(sd_wr), 32'd0);
    tick();
    for (int a = 0; a < 512; a++) begin
      sd_buff_addr = 9'(a);
      exp_byte_q.push_back(8'(a));
      tick();
      check("wr_din", 32'(sd_buff_din), 32'(exp_byte_q.pop_front()));
    end
    exp_ev_q.push_back(EV_DONE);
    sd_ack = 1'b0;
    tick();
    check("wr_no_early_pulse", 32'({done, err}), 32'd0);
    tick();
    check("wr_pulse", 32'({done, err}), 32'(EV_DONE));
    tick();
    check("wr_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_sd_rd_wr", 32'({sd_rd, sd_wr}), 32'd0);
    check("rst_sd_lba", sd_lba, 32'd0);
    reset = 1'b0;
    tick();

    // Full read: bytes addr^0x5A
    do_read(32'h0000_0123, 512, 8'h5A);
    rd_buf("rd_buf_1ff", 'h1FF, 8'hA5);
    rd_buf("rd_buf_000", 0, 8'h5A);

    // Preload buffer with addr[7:0], then write it out
    for (int a = 0; a < 512; a++) begin
      buf_addr  = 9'(a);
      buf_wdata = 8'(a);
      buf_we    = 1'b1;
      tick();
    end
    buf_we = 1'b0;
    do_write(32'd7, 1'b0);

    // Second req_wr and buf_we while busy are both ignored
    do_write(32'd9, 1'b1);
    rd_buf("busy_we_ignored", 10, 8'h0A);

    // Short read: 300 strobes of ~addr
    do_read(32'h0000_0200, 300, 8'hFF);
    rd_buf("short_first", 0, 8'hFF);
    rd_buf("short_last_written", 299, 8'hD4);
    rd_buf("short_first_kept", 300, 8'h2C);
    rd_buf("short_end_kept", 511, 8'hFF);

    // Timeout, with simultaneous req_rd/req_wr (read wins)
    exp_ev_q.push_back(EV_ERR);
    req_lba = 32'h77;
    req_rd  = 1'b1;
    req_wr  = 1'b1;
    tick();
    req_rd = 1'b0;
    req_wr = 1'b0;
    check("both_req_sd_rd", 32'(sd_rd), 32'd1);
    check("both_req_sd_wr", 32'(sd_wr), 32'd0);
    repeat (98) tick();
    check("to_before_err", 32'(err), 32'd0);
    check("to_before_sd_rd", 32'(sd_rd), 32'd1);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_sd_rd_dropped", 32'(sd_rd), 32'd0);
    check("to_busy_at_err", 32'(busy), 32'd1);
    tick();
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_no_pulse_after", 32'({done, err}), 32'd0);

    // Reset in the middle of a read transfer with sd_ack high
    req_lba = 32'h42;
    req_rd  = 1'b1;
    tick();
    req_rd = 1'b0;
    repeat (3) tick();
    sd_ack = 1'b1;
    repeat (4) tick();
    for (int a = 0; a < 20; a++) begin
      sd_buff_addr = 9'(a);
      sd_buff_dout = 8'(a) ^ 8'h11;
      sd_buff_wr   = 1'b1;
      tick();
    end
    sd_buff_wr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sd_rd_wr", 32'({sd_rd, sd_wr}), 32'd0);
    check("mid_rst_sd_lba", sd_lba, 32'd0);
    check("mid_rst_pulse", 32'({done, err}), 32'd0);
    repeat (5) tick();
    check("mid_rst_ack_ignored", 32'(busy), 32'd0);
    sd_ack = 1'b0;
    repeat (3) tick();
    do_read(32'h0000_0099, 512, 8'hC3);
    rd_buf("post_rst_buf_1ff", 'h1FF, 8'h3C);

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_ev_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
